serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor computing A − B one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the subtracting counterpart to the combinational full-adder cell in the arithmetic library. It trades latency for area, with valid/ready handshakes on operand input and result output. It sits in area-constrained datapaths where one result per WIDTH+2 cycles is sufficient.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2–32
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a − b, modulo 2^WIDTH
- bout  output  1  final borrow (unsigned a < b)
- ovf  output  1  signed overflow of a − b

## Operation
- States: IDLE, SHIFT, DONE. There is one operation in flight at a time.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid&in_ready:
    - Load a into shift register ra and b into rb.
    - Set borrow=0 and bit counter cnt=0.
    - Capture sign bits a[WIDTH-1] and b[WIDTH-1].
    - Go to SHIFT.
- SHIFT, each edge:
  - Let x=ra[0], y=rb[0], br=borrow.
  - Difference bit d = x^y^br.
  - Next borrow = (~x&y) | (~(x^y)&br).
  - Shift ra and rb right by one.
  - Shift d into the result register from the MSB end.
  - cnt increments. On the edge where cnt==WIDTH-1, go to DONE.
- Entering DONE:
  - bout = final borrow.
  - ovf = (a_sign != b_sign) && (diff[WIDTH-1] != a_sign).
  - diff, bout and ovf are registered.
- DONE:
  - out_valid=1, in_ready=0.
  - diff, bout and ovf hold stable until the handshake.
  - On an edge with out_valid&out_ready, go to IDLE.
- in_valid is ignored whenever in_ready=0. Changes on a and b after acceptance have no effect on the result.
- diff, bout and ovf keep the last result after returning to IDLE. They are meaningful only while out_valid=1.
- cnt width is clog2(WIDTH); the counter never wraps within an operation.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, diff=0, bout=0, ovf=0.
  - State=IDLE, borrow=0, cnt=0.
- Reset mid-operation (SHIFT or DONE):
  - The in-flight operation is discarded and no result is ever presented.
  - in_ready=1 in the cycle after the reset edge.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: with out_ready held high and in_valid held high, operands are accepted every WIDTH+2 edges:
  - 1 accept edge,
  - WIDTH shift edges (the last of which enters DONE),
  - 1 output handshake edge.
- in_ready and out_valid are never high in the same cycle.
- All outputs are driven from registers, with no combinational path from inputs to outputs.
- A new operand cannot be accepted on the same edge as the output handshake. Acceptance earliest occurs on the following edge.

## Test plan
All scenarios use WIDTH=8.
- **Basic:** a=0x5A, b=0x3C accepted at edge E.
  - Expect out_valid high after edge E+8, diff=0x1E, bout=0, ovf=0.
  - in_ready stays low from E+1 through the handshake.
- **Unsigned underflow:** a=0x00, b=0x01.
  - Expect diff=0xFF, bout=1, ovf=0.
- **Signed overflow:** two cases.
  - a=0x80, b=0x01: diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF: diff=0x80, bout=1, ovf=1.
- **Backpressure:** a=0x33, b=0x11, out_ready low for 5 cycles after out_valid rises.
  - Meanwhile drive in_valid=1 with a=0xFF, b=0xFF.
  - Expect diff=0x22 stable throughout, in_ready=0, and the second operands not accepted.
  - After out_ready=1, handshake completes and in_ready=1 on the next cycle.
- **Reset mid-operation:** a=0xAA, b=0x55, rst_n low for one edge after the 4th shift edge.
  - Expect out_valid=0, diff=0, bout=0, ovf=0, in_ready=1 the cycle after.
  - No result for 0xAA−0x55 is ever presented.
  - Then a=0x10, b=0x10 gives diff=0x00, bout=0, ovf=0.
- **Back-to-back:** in_valid and out_ready held high.
  - Operands 0x09−0x04, then 0x04−0x09.
  - Expect results 0x05/bout=0, then 0xFB/bout=1.
  - Second acceptance occurs exactly 10 edges after the first.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, through a single full-subtractor cell with a registered borrow.
// One operation in flight; valid/ready handshakes on both operand and result.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_sign;
  logic             b_sign;
  logic             x;
  logic             y;
  logic             d;
  logic             borrow_next;
  logic             last;

  // Full-subtractor cell on the current LSBs plus last-bit detection.
  always_comb begin
    x           = ra[0];
    y           = rb[0];
    d           = x ^ y ^ borrow;
    borrow_next = (~x & y) | (~(x ^ y) & borrow);
    last        = (cnt == CW'(WIDTH - 1));
  end

  // Next-state decode: accept in IDLE, shift WIDTH bits, hold result in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = SHIFT;
      SHIFT:   if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Handshake flags registered from the next state so they track the FSM
  // exactly while having no combinational path from inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Datapath: operand capture, serial shift, result/flag registration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra     <= a;
            rb     <= b;
            cnt    <= '0;
            borrow <= 1'b0;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          ra     <= {1'b0, ra[WIDTH-1:1]};
          rb     <= {1'b0, rb[WIDTH-1:1]};
          res    <= {d, res[WIDTH-1:1]};
          borrow <= borrow_next;
          // Counter is cleared on the final bit instead of incremented so it
          // never wraps when WIDTH is a power of two.
          if (last) begin
            cnt  <= '0;
            diff <= {d, res[WIDTH-1:1]};
            bout <= borrow_next;
            ovf  <= (a_sign != b_sign) && (d != a_sign);
          end else begin
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
